// File: rtl/multiport_memory_pkg.sv
// Shared types and helpers for the multiport memory and its read ports.
package multiport_memory_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_e;

    localparam int unsigned LAT_COMB    = 0;
    localparam int unsigned LAT_REG     = 1;
    localparam int unsigned LAT_REG_OUT = 2;

    // Widest word the merge helper handles; callers cast to/from their width.
    localparam int unsigned MERGE_BYTES = 64;
    localparam int unsigned MERGE_DW    = MERGE_BYTES * 8;

    function automatic logic [MERGE_DW-1:0] byte_mask_merge(
        input logic [MERGE_DW-1:0]    old_word,
        input logic [MERGE_DW-1:0]    new_word,
        input logic [MERGE_BYTES-1:0] mask
    );
        logic [MERGE_DW-1:0] merged;
        merged = old_word;
        for (int unsigned b = 0; b < MERGE_BYTES; b++) begin
            if (mask[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/multiport_memory_read_port.sv
// One independent read port: range check, write-first bypass, 0/1/2-cycle pipeline.
module memory_read_port
    import multiport_memory_pkg::*;
#(
    parameter int unsigned DW           = 64,
    parameter int unsigned AW           = 6,
    parameter int unsigned NBYTES       = 8,
    parameter int unsigned MEM_DEPTH    = 64,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned WRITE_FIRST  = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              busy_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    input  logic [DW-1:0]     mem_word_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DW-1:0]     wr_data_i,
    input  logic [NBYTES-1:0] wr_mask_i,
    output logic [DW-1:0]     rd_data_o,
    output logic              rd_valid_o
);

    logic          in_range;
    logic          bypass_hit;
    logic [DW-1:0] word_c;
    logic          valid_c;

    // Resolve the word this port sees this cycle, including the write-first merge
    always_comb begin
        in_range   = 32'(rd_addr_i) < MEM_DEPTH;
        bypass_hit = (WRITE_FIRST != 0) && wr_en_i && (wr_addr_i == rd_addr_i);
        valid_c    = rd_en_i && !busy_i;
        word_c     = '0;
        if (in_range) begin
            if (bypass_hit) begin
                word_c = DW'(byte_mask_merge(MERGE_DW'(mem_word_i), MERGE_DW'(wr_data_i),
                                             MERGE_BYTES'(wr_mask_i)));
            end else begin
                word_c = mem_word_i;
            end
        end
    end

    if (READ_LATENCY == LAT_COMB) begin : g_lat0
        assign rd_data_o  = word_c;
        assign rd_valid_o = valid_c;
    end else begin : g_reg
        logic [DW-1:0] data1_q, data1_d;
        logic          valid1_q;

        // First stage holds its data when no request is sampled
        always_comb begin
            data1_d = data1_q;
            if (valid_c) data1_d = word_c;
        end

        // First-stage registers; bypass decision is already folded into word_c
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                data1_q  <= '0;
                valid1_q <= 1'b0;
            end else begin
                data1_q  <= data1_d;
                valid1_q <= valid_c;
            end
        end

        if (READ_LATENCY == LAT_REG) begin : g_lat1
            assign rd_data_o  = data1_q;
            assign rd_valid_o = valid1_q;
        end else begin : g_lat2
            logic [DW-1:0] data2_q;
            logic          valid2_q;

            // Output register: plain one-cycle delay of the first stage
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    data2_q  <= '0;
                    valid2_q <= 1'b0;
                end else begin
                    data2_q  <= data1_q;
                    valid2_q <= valid1_q;
                end
            end

            assign rd_data_o  = data2_q;
            assign rd_valid_o = valid2_q;
        end
    end

endmodule

// File: rtl/multiport_memory.sv
// Byte-masked RAM with one write port, READ_PORTS read ports and post-reset self-clear.
module multiport_memory
    import multiport_memory_pkg::*;
#(
    parameter  int unsigned MEM_WIDTH_BYTES = 8,
    parameter  int unsigned MEM_DEPTH       = 64,
    parameter  int unsigned READ_PORTS      = 2,
    parameter  int unsigned READ_LATENCY    = 1,
    parameter  int unsigned WRITE_FIRST     = 1,
    parameter  int unsigned CLEAR_ON_RESET  = 1,
    localparam int unsigned DW              = MEM_WIDTH_BYTES * 8,
    localparam int unsigned AW              = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AW-1:0]              write_addr_in,
    input  logic                       write_in,
    input  logic [DW-1:0]              write_data_in,
    input  logic [MEM_WIDTH_BYTES-1:0] write_mask_in,
    input  logic [READ_PORTS*AW-1:0]   read_addr_in,
    input  logic [READ_PORTS-1:0]      read_in,
    output logic [READ_PORTS*DW-1:0]   read_data_out,
    output logic [READ_PORTS-1:0]      read_valid_out,
    output logic                       busy_out,
    input  logic                       debugen_in
);

    logic [DW-1:0] mem_q [MEM_DEPTH];

    mem_state_e    state_q, state_d;
    logic [AW-1:0] clear_cnt_q, clear_cnt_d;
    logic          clear_we;
    logic          busy;
    logic          wr_en;

    assign busy     = (state_q == CLEAR);
    assign busy_out = busy;

    // Writes are dropped while clearing and when the address is past the last entry
    always_comb begin
        wr_en = write_in && !busy && (32'(write_addr_in) < MEM_DEPTH);
    end

    // Clear FSM next-state: sweep every entry once, then open for traffic
    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        clear_we    = 1'b0;
        case (state_q)
            CLEAR: begin
                clear_we = !reset;
                if (clear_cnt_q == AW'(MEM_DEPTH - 1)) begin
                    state_d     = READY;
                    clear_cnt_d = '0;
                end else begin
                    clear_cnt_d = clear_cnt_q + 1'b1;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    // Clear FSM state register; reset restarts the sweep from entry 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clear_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_cnt_q <= clear_cnt_d;
        end
    end

    // Storage update: clear sweep has priority, otherwise byte-masked write
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem_q[clear_cnt_q] <= '0;
        end else if (wr_en) begin
            for (int unsigned b = 0; b < MEM_WIDTH_BYTES; b++) begin
                if (write_mask_in[b]) mem_q[write_addr_in][b*8 +: 8] <= write_data_in[b*8 +: 8];
            end
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        logic [AW-1:0] addr;
        logic [DW-1:0] word;
        logic [DW-1:0] data;
        logic          valid;

        assign addr = read_addr_in[p*AW +: AW];

        // Guard the array index; the port itself defines out-of-range results
        always_comb begin
            word = '0;
            if (32'(addr) < MEM_DEPTH) word = mem_q[addr];
        end

        memory_read_port #(
            .DW           (DW),
            .AW           (AW),
            .NBYTES       (MEM_WIDTH_BYTES),
            .MEM_DEPTH    (MEM_DEPTH),
            .READ_LATENCY (READ_LATENCY),
            .WRITE_FIRST  (WRITE_FIRST)
        ) u_port (
            .clk_i      (clk),
            .reset_i    (reset),
            .busy_i     (busy),
            .rd_en_i    (read_in[p]),
            .rd_addr_i  (addr),
            .mem_word_i (word),
            .wr_en_i    (wr_en),
            .wr_addr_i  (write_addr_in),
            .wr_data_i  (write_data_in),
            .wr_mask_i  (write_mask_in),
            .rd_data_o  (data),
            .rd_valid_o (valid)
        );

        assign read_data_out[p*DW +: DW] = data;
        assign read_valid_out[p]         = valid;
    end

`ifndef SYNTHESIS
    // Per-cycle trace of write inputs and every read port
    always_ff @(posedge clk) begin
        if (debugen_in) begin
            $write("%0t mpm we=%b wa=%0d wd=%h wm=%h busy=%b", $time, write_in, write_addr_in,
                   write_data_in, write_mask_in, busy);
            for (int unsigned p = 0; p < READ_PORTS; p++) begin
                $write(" | p%0d re=%b a=%0d d=%h v=%b", p, read_in[p], read_addr_in[p*AW +: AW],
                       read_data_out[p*DW +: DW], read_valid_out[p]);
            end
            $write("\n");
        end
    end
`endif

endmodule
